// File: rtl/mic1_exec_ctrl.sv
// mic1_exec_ctrl: run/step/halt execution controller for the Mic-1 core.
// Turns single-cycle button commands into microcycle requests over a
// req/done handshake, guards each request with a watchdog, and drives the
// status LEDs. All outputs are registered.
//
// Optional build macro: MIC1_EXEC_BREAKPOINT_EN adds i_bp_addr/i_bp_enable.
// When enabled, a completed run microcycle whose micro-PC matches the
// breakpoint address ends the run.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no request outstanding, waiting for run/step command
// ST_STEP_REQ | single-step microcycle requested, waiting for done
// ST_RUN_REQ  | continuous run, microcycle requested, waiting for done
// ST_RUN_GAP  | continuous run, one-cycle gap between requests
// ST_FAULT    | handshake watchdog expired; left only through reset

module mic1_exec_ctrl #(
    parameter int STEP_CNT_W = 4,
    parameter int TIMEOUT_W  = 8,
    parameter int MPC_W      = 9
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_cmd_run,
    input  logic                  i_cmd_step,
    input  logic                  i_cmd_halt,
    input  logic                  i_core_halt,
    input  logic                  i_cyc_done,
    input  logic [MPC_W-1:0]      i_core_mpc,
`ifdef MIC1_EXEC_BREAKPOINT_EN
    input  logic [MPC_W-1:0]      i_bp_addr,
    input  logic                  i_bp_enable,
`endif
    output logic                  o_cyc_req,
    output logic                  o_led_run_status,
    output logic                  o_led_idle,
    output logic                  o_led_fault,
    output logic [STEP_CNT_W-1:0] o_led_step_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STEP_REQ = 3'd1,
        ST_RUN_REQ  = 3'd2,
        ST_RUN_GAP  = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    // Watchdog trips when the count would reach all-ones, so cyc_req is
    // held for exactly 2**TIMEOUT_W-1 cycles before the fault.
    localparam logic [TIMEOUT_W-1:0] WD_TRIP = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t                r_state;
    logic                  r_halt_pend;
    logic [TIMEOUT_W-1:0]  r_wd;
    logic [STEP_CNT_W-1:0] r_step_cnt;
    logic                  r_cyc_req;
    logic                  r_led_run;
    logic                  r_led_idle;
    logic                  r_led_fault;

    state_t                w_state_nxt;
    logic                  w_halt_pend_nxt;
    logic [TIMEOUT_W-1:0]  w_wd_nxt;
    logic [STEP_CNT_W-1:0] w_step_cnt_nxt;
    logic                  w_stop;
    logic                  w_bp_hit;

`ifdef MIC1_EXEC_BREAKPOINT_EN
    assign w_bp_hit = i_bp_enable && (i_core_mpc == i_bp_addr);
`else
    logic w_unused_mpc;
    assign w_unused_mpc = ^i_core_mpc;
    assign w_bp_hit     = 1'b0;
`endif

    assign w_stop = r_halt_pend | i_cmd_halt | i_core_halt;

    // Next-state, watchdog, step counter and halt-pending decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_halt_pend_nxt = r_halt_pend;
        w_wd_nxt        = r_wd;
        w_step_cnt_nxt  = r_step_cnt;

        case (r_state)
            ST_IDLE: begin
                if (!i_core_halt) begin
                    if (i_cmd_step) begin
                        w_state_nxt = ST_STEP_REQ;
                        w_wd_nxt    = '0;
                    end else if (i_cmd_run) begin
                        w_state_nxt = ST_RUN_REQ;
                        w_wd_nxt    = '0;
                    end
                end
            end
            ST_STEP_REQ: begin
                if (i_cyc_done) begin
                    w_step_cnt_nxt = r_step_cnt + 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                    if (r_wd == WD_TRIP) begin
                        w_state_nxt = ST_FAULT;
                    end
                end
            end
            ST_RUN_REQ: begin
                if (i_cyc_done) begin
                    w_step_cnt_nxt = r_step_cnt + 1'b1;
                    w_state_nxt    = (w_stop || w_bp_hit) ? ST_IDLE : ST_RUN_GAP;
                end else begin
                    if (i_cmd_halt) begin
                        w_halt_pend_nxt = 1'b1;
                    end
                    w_wd_nxt = r_wd + 1'b1;
                    if (r_wd == WD_TRIP) begin
                        w_state_nxt = ST_FAULT;
                    end
                end
            end
            ST_RUN_GAP: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN_REQ;
                    w_wd_nxt    = '0;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A pending halt only has meaning while a run is still in progress.
        if (w_state_nxt != ST_RUN_REQ && w_state_nxt != ST_RUN_GAP) begin
            w_halt_pend_nxt = 1'b0;
        end
    end

    // State, counters and registered outputs; outputs decode the next state
    // so they change together with the state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_halt_pend <= 1'b0;
            r_wd        <= '0;
            r_step_cnt  <= '0;
            r_cyc_req   <= 1'b0;
            r_led_run   <= 1'b0;
            r_led_idle  <= 1'b1;
            r_led_fault <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            r_wd        <= w_wd_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_cyc_req   <= (w_state_nxt == ST_STEP_REQ) || (w_state_nxt == ST_RUN_REQ);
            r_led_run   <= (w_state_nxt == ST_RUN_REQ) || (w_state_nxt == ST_RUN_GAP);
            r_led_idle  <= (w_state_nxt == ST_IDLE);
            r_led_fault <= (w_state_nxt == ST_FAULT);
        end
    end

    assign o_cyc_req        = r_cyc_req;
    assign o_led_run_status = r_led_run;
    assign o_led_idle       = r_led_idle;
    assign o_led_fault      = r_led_fault;
    assign o_led_step_cnt   = r_step_cnt;

endmodule

// File: tb/tb_mic1_exec_ctrl.sv
// Testbench for mic1_exec_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the controller.

module tb_mic1_exec_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
    logic       core_halt = 1'b0, cyc_done = 1'b0;
    logic [8:0] core_mpc = 9'd0;
    logic       o_cyc_req, o_led_run_status, o_led_idle, o_led_fault;
    logic [3:0] o_led_step_cnt;
    logic [7:0] dut_vec;

    int errors = 0;
    int checks = 0;

    // Reference model: a request is outstanding or not, a run is active or
    // not, a gap follows each completed run microcycle.
    bit m_busy, m_running, m_gap, m_pend, m_fault;
    int m_cnt, m_wd;
    int req_age;

    mic1_exec_ctrl #(.STEP_CNT_W(4), .TIMEOUT_W(8), .MPC_W(9)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_cmd_run        (cmd_run),
        .i_cmd_step       (cmd_step),
        .i_cmd_halt       (cmd_halt),
        .i_core_halt      (core_halt),
        .i_cyc_done       (cyc_done),
        .i_core_mpc       (core_mpc),
`ifdef MIC1_EXEC_BREAKPOINT_EN
        .i_bp_addr        (9'd0),
        .i_bp_enable      (1'b0),
`endif
        .o_cyc_req        (o_cyc_req),
        .o_led_run_status (o_led_run_status),
        .o_led_idle       (o_led_idle),
        .o_led_fault      (o_led_fault),
        .o_led_step_cnt   (o_led_step_cnt)
    );

    always #5 clk = ~clk;

    assign dut_vec = {o_cyc_req, o_led_run_status, o_led_idle, o_led_fault, o_led_step_cnt};

    function automatic logic [7:0] exp_vec();
        logic [3:0] c;
        c = 4'(m_cnt);
        return {m_busy, m_running, (!m_fault && !m_busy && !m_running), m_fault, c};
    endfunction

    task automatic model_step();
        if (!resetn) begin
            m_busy = 0; m_running = 0; m_gap = 0; m_pend = 0; m_fault = 0;
            m_cnt = 0; m_wd = 0;
        end else if (m_fault) begin
            m_fault = 1;
        end else if (m_busy) begin
            if (cyc_done) begin
                m_cnt  = (m_cnt + 1) % 16;
                m_busy = 0;
                if (m_running) begin
                    if (m_pend || cmd_halt || core_halt) begin
                        m_running = 0;
                        m_pend    = 0;
                    end else begin
                        m_gap = 1;
                    end
                end
            end else begin
                m_wd++;
                if (m_running && cmd_halt) m_pend = 1;
                if (m_wd >= 255) begin
                    m_fault = 1; m_busy = 0; m_running = 0; m_pend = 0;
                end
            end
        end else if (m_gap) begin
            m_gap = 0;
            if (m_pend || cmd_halt || core_halt) begin
                m_running = 0;
                m_pend    = 0;
            end else begin
                m_busy = 1;
                m_wd   = 0;
            end
        end else if (!core_halt) begin
            if (cmd_step) begin
                m_busy = 1; m_wd = 0;
            end else if (cmd_run) begin
                m_busy = 1; m_running = 1; m_wd = 0;
            end
        end
    endtask

    // One clock: model follows the edge, pulses are cleared, and the core
    // stand-in answers a request on its lat-th cycle (lat=0: never).
    task automatic tick(input int lat);
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmd_run  = 0;
        cmd_step = 0;
        cmd_halt = 0;
        req_age  = o_cyc_req ? req_age + 1 : 0;
        cyc_done = (lat > 0) && o_cyc_req && (req_age == lat);
    endtask

    task automatic do_reset();
        resetn = 0;
        tick(0);
        resetn = 1;
    endtask

    task automatic test_reset();
        cmd_run = 1; cmd_step = 1; cyc_done = 1;
        do_reset();
        checks++;
        if (dut_vec !== 8'h20) begin
            errors++;
            $display("FAIL reset_values: got=%h want=%h", dut_vec, 8'h20);
        end
        tick(0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_hold: got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_single_step();
        int pulses = 0;
        bit prev = 0, run_seen = 0;
        do_reset();
        cmd_step = 1;
        for (int i = 0; i < 12; i++) begin
            tick(3);
            if (o_cyc_req && !prev) pulses++;
            prev = o_cyc_req;
            if (o_led_run_status) run_seen = 1;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL step_cycle%0d: got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (pulses !== 1 || o_led_step_cnt !== 4'd1 || o_led_idle !== 1'b1 || run_seen) begin
            errors++;
            $display("FAIL step_summary: pulses=%0d cnt=%0d idle=%b run_seen=%b want 1/1/1/0",
                     pulses, o_led_step_cnt, o_led_idle, run_seen);
        end
    endtask

    task automatic test_run_halt();
        int dones = 0, budget = 0;
        bit halted = 0;
        do_reset();
        cmd_run = 1;
        do begin
            tick(2);
            budget++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL run_cycle%0d: got=%h want=%h", budget, dut_vec, exp_vec());
            end
            if (cyc_done) dones++;
            if (!halted && dones == 5 && o_cyc_req && req_age == 1) begin
                cmd_halt = 1;
                halted   = 1;
            end
        end while (!(o_led_idle && budget > 1) && budget < 100);
        checks++;
        if (budget >= 100 || o_led_step_cnt !== 4'd6 || o_led_idle !== 1'b1 || dones !== 6) begin
            errors++;
            $display("FAIL run_halt_end: cnt=%0d idle=%b dones=%0d cycles=%0d want cnt 6 idle 1",
                     o_led_step_cnt, o_led_idle, dones, budget);
        end
    endtask

    task automatic test_wrap();
        int budget;
        do_reset();
        for (int s = 0; s < 16; s++) begin
            cmd_step = 1;
            budget   = 0;
            do begin
                tick(1 + (s % 4));
                budget++;
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL wrap_s%0d: got=%h want=%h", s, dut_vec, exp_vec());
                end
            end while (!o_led_idle && budget < 20);
            checks++;
            if (o_led_step_cnt !== 4'((s + 1) % 16) || o_led_fault !== 1'b0) begin
                errors++;
                $display("FAIL wrap_cnt%0d: cnt=%0d fault=%b want cnt=%0d fault=0",
                         s, o_led_step_cnt, o_led_fault, (s + 1) % 16);
            end
        end
    endtask

    task automatic test_watchdog();
        int hi = 0;
        do_reset();
        cmd_run = 1;
        tick(0);
        while (o_cyc_req && hi < 400) begin
            hi++;
            tick(0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL wd_cycle%0d: got=%h want=%h", hi, dut_vec, exp_vec());
            end
        end
        checks++;
        if (hi !== 255 || o_led_fault !== 1'b1 || o_cyc_req !== 1'b0) begin
            errors++;
            $display("FAIL wd_trip: req_cycles=%0d fault=%b req=%b want 255/1/0", hi, o_led_fault, o_cyc_req);
        end
        for (int i = 0; i < 6; i++) begin
            cmd_step = (i % 2 == 0);
            cmd_run  = (i % 2 == 1);
            cyc_done = 1;
            tick(0);
            checks++;
            if (dut_vec !== exp_vec() || o_led_fault !== 1'b1) begin
                errors++;
                $display("FAIL fault_hold%0d: got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        do_reset();
        checks++;
        if (dut_vec !== 8'h20) begin
            errors++;
            $display("FAIL fault_reset: got=%h want=%h", dut_vec, 8'h20);
        end
    endtask

    task automatic test_core_halt();
        int dones = 0, budget = 0;
        bit req_seen = 0;
        do_reset();
        core_halt = 1;
        for (int i = 0; i < 4; i++) begin
            cmd_run  = (i == 0);
            cmd_step = (i == 1);
            tick(0);
            if (o_cyc_req) req_seen = 1;
        end
        checks++;
        if (req_seen || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL core_halt_idle: req_seen=%b got=%h want=%h", req_seen, dut_vec, exp_vec());
        end
        core_halt = 0;
        cmd_run   = 1;
        do begin
            tick(2);
            budget++;
            if (cyc_done) begin
                dones++;
                if (dones == 3) core_halt = 1;
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL core_halt_run%0d: got=%h want=%h", budget, dut_vec, exp_vec());
            end
        end while (!(o_led_idle && budget > 1) && budget < 60);
        checks++;
        if (o_led_step_cnt !== 4'd3 || o_led_idle !== 1'b1) begin
            errors++;
            $display("FAIL core_halt_end: cnt=%0d idle=%b want cnt 3 idle 1", o_led_step_cnt, o_led_idle);
        end
        core_halt = 0;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        bit prev = 0;
        do_reset();
        cmd_step = 1;
        cmd_run  = 1;
        for (int i = 0; i < 10; i++) begin
            tick(2);
            if (o_cyc_req && !prev) pulses++;
            prev = o_cyc_req;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL step_run_cycle%0d: got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (pulses !== 1 || o_led_idle !== 1'b1 || o_led_step_cnt !== 4'd1) begin
            errors++;
            $display("FAIL step_run_same: pulses=%0d idle=%b cnt=%0d want 1/1/1", pulses, o_led_idle, o_led_step_cnt);
        end
        do_reset();
        cmd_step = 1;
        tick(0);
        tick(0);
        resetn = 0;
        tick(0);
        resetn = 1;
        checks++;
        if (o_cyc_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_req: req=%b want 0", o_cyc_req);
        end
        cyc_done = 1;
        tick(0);
        tick(0);
        checks++;
        if (o_led_step_cnt !== 4'd0 || o_led_idle !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL late_done: cnt=%0d idle=%b want cnt 0 idle 1", o_led_step_cnt, o_led_idle);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            resetn   = ($urandom_range(0, 299) != 0);
            cmd_run  = ($urandom_range(0, 19) == 0);
            cmd_step = ($urandom_range(0, 24) == 0);
            cmd_halt = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 39) == 0) core_halt = ~core_halt;
            core_mpc = 9'($urandom);
            cyc_done = o_cyc_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            tick(0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random%0d: got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        core_halt = 0;
        resetn    = 1;
    endtask

    initial begin
        req_age = 0;
        m_busy = 0; m_running = 0; m_gap = 0; m_pend = 0; m_fault = 0;
        m_cnt = 0; m_wd = 0;
        @(negedge clk);
        test_reset();
        test_single_step();
        test_run_halt();
        test_wrap();
        test_watchdog();
        test_core_halt();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
